// File: rtl/fc_stream_engine.sv
// fc_stream_engine: streaming fully-connected layer.
// Loads the input vector x once, then for every neuron takes a bias beat and
// the weight row. Each weight beat's LANES products are accumulated as the
// beat is accepted. Each finished neuron is shifted, optionally rectified,
// saturated, and then held in a single output register until downstream
// accepts it.
module fc_stream_engine #(
    parameter int DATA_W  = 8,
    parameter int IN_LEN  = 4,
    parameter int OUT_NUM = 4,
    parameter int LANES   = 4,
    parameter int SIGNED  = 1,
    parameter int OUT_W   = 16,
    parameter int ACC_W   = 2*DATA_W + $clog2(IN_LEN) + 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [1:0]                                  act_mode,
    input  logic [3:0]                                  out_shift,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [LANES*DATA_W-1:0]                     in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [OUT_W-1:0]                            out_data,
    output logic [((OUT_NUM > 1) ? $clog2(OUT_NUM) : 1)-1:0] out_idx,
    output logic                                        busy,
    output logic                                        done
);

    localparam int SEGS  = IN_LEN / LANES;
    localparam int SEG_W = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam int IDX_W = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
    localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_X, S_LOAD_B, S_LOAD_W, S_DRAIN} state_t;

    state_t                   r_state, w_state_nxt;
    logic [SEG_W-1:0]         r_seg;
    logic [IDX_W-1:0]         r_neu;
    logic [1:0]               r_act;
    logic [3:0]               r_shift;
    logic [DATA_W-1:0]        r_xbuf [SEGS][LANES];
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_prod_sum;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic                     r_out_valid;
    logic [OUT_W-1:0]         r_out_data;
    logic [IDX_W-1:0]         r_out_idx;
    logic                     r_done;
    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_seg_last;
    logic                     w_neu_last;
    logic                     w_out_hs;
    logic                     w_last_w;

    // Widen an operand to accumulator width with the configured signedness.
    function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
        if (SIGNED != 0) ext = {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
        else             ext = {{(ACC_W-DATA_W){1'b0}}, v};
    endfunction

    // Output scaling shift followed by the optional ReLU.
    function automatic logic signed [ACC_W-1:0] shift_act(input logic signed [ACC_W-1:0] a,
                                                          input logic [1:0] mode,
                                                          input logic [3:0] sh);
        logic signed [ACC_W-1:0] s;
        if (SIGNED != 0) s = a >>> sh;
        else             s = $signed($unsigned(a) >> sh);
        if (mode == 2'b01 && s < 0) s = '0;
        return s;
    endfunction

    // Clamp to the representable output range; compare in a wider type so the
    // bounds themselves never wrap.
    function automatic logic [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [CMP_W-1:0] v, hi, lo, one;
        one = {{(CMP_W-1){1'b0}}, 1'b1};
        v   = {{(CMP_W-ACC_W){a[ACC_W-1]}}, a};
        if (SIGNED != 0) begin
            hi = (one <<< (OUT_W-1)) - one;
            lo = -(one <<< (OUT_W-1));
        end else begin
            hi = (one <<< OUT_W) - one;
            lo = '0;
        end
        if (v > hi)      v = hi;
        else if (v < lo) v = lo;
        return v[OUT_W-1:0];
    endfunction

    assign w_accept   = in_valid & w_in_ready;
    assign w_seg_last = (r_seg == SEG_W'(SEGS-1));
    assign w_neu_last = (r_neu == IDX_W'(OUT_NUM-1));
    assign w_out_hs   = r_out_valid & out_ready;
    assign w_last_w   = (r_state == S_LOAD_W) && w_seg_last;
    assign w_acc_sum  = r_acc + w_prod_sum;

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

    // Sum of this beat's lane products against the matching stored x segment.
    always_comb begin
        w_prod_sum = '0;
        for (int j = 0; j < LANES; j++)
            w_prod_sum = w_prod_sum + ext(in_data[(LANES-1-j)*DATA_W +: DATA_W]) * ext(r_xbuf[r_seg][j]);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and input acceptance; the last weight beat stalls while the
    // output register is full and not draining this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD_X;
            end
            S_LOAD_X: begin
                w_in_ready = 1'b1;
                if (in_valid && w_seg_last) w_state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_LOAD_W;
            end
            S_LOAD_W: begin
                w_in_ready = !(w_seg_last && r_out_valid && !out_ready);
                if (in_valid && w_in_ready && w_seg_last)
                    w_state_nxt = w_neu_last ? S_DRAIN : S_LOAD_B;
            end
            S_DRAIN: begin
                if (w_out_hs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Beat-within-segment and neuron counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= '0;
            r_neu <= '0;
        end else if (r_state == S_IDLE) begin
            r_seg <= '0;
            r_neu <= '0;
        end else if (w_accept && (r_state == S_LOAD_X || r_state == S_LOAD_W)) begin
            r_seg <= w_seg_last ? '0 : r_seg + 1'b1;
            if (r_state == S_LOAD_W && w_seg_last)
                r_neu <= w_neu_last ? '0 : r_neu + 1'b1;
        end
    end

    // Job configuration captured at start so later input changes cannot disturb a job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act   <= '0;
            r_shift <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_act   <= act_mode;
            r_shift <= out_shift;
        end
    end

    // x vector buffer, one segment per accepted x beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SEGS; s++)
                for (int j = 0; j < LANES; j++)
                    r_xbuf[s][j] <= '0;
        end else if (w_accept && r_state == S_LOAD_X) begin
            for (int j = 0; j < LANES; j++)
                r_xbuf[r_seg][j] <= in_data[(LANES-1-j)*DATA_W +: DATA_W];
        end
    end

    // Accumulator: seeded with the bias, then grows by each weight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept && r_state == S_LOAD_B) begin
            r_acc <= ext(in_data[LANES*DATA_W-1 -: DATA_W]);
        end else if (w_accept && r_state == S_LOAD_W) begin
            r_acc <= w_acc_sum;
        end
    end

    // Output register: loads on the last weight beat, may drain and refill in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
        end else if (w_accept && w_last_w) begin
            r_out_valid <= 1'b1;
            r_out_data  <= saturate(shift_act(w_acc_sum, r_act, r_shift));
            r_out_idx   <= r_neu;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    // Completion pulse after the final result leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_done <= 1'b0;
        else     r_done <= (r_state == S_DRAIN) && w_out_hs;
    end

endmodule

// File: tb/tb_fc_stream_engine.sv
// Bench for fc_stream_engine: a default signed instance and an 8-long,
// 2-neuron unsigned instance, both driven from job tables and random jobs and
// compared against a plain-arithmetic reference of the layer.
module tb_fc_stream_engine;

    localparam int LIMIT = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s    [2];
    logic [1:0]  act_s      [2];
    logic [3:0]  shift_s    [2];
    logic        in_valid_s [2];
    logic        in_ready_s [2];
    logic [31:0] in_data_s  [2];
    logic        out_valid_s[2];
    logic        out_ready_s[2];
    logic [15:0] out_data_s [2];
    logic        busy_s     [2];
    logic        done_s     [2];
    logic [1:0]  idx0;
    logic [0:0]  idx1;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] idx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;
    int   rmode[2];
    bit   pend_done[2];
    bit   gaps;
    int   cap[2][4];
    int   jx[8];
    int   jw[4][8];
    int   jb[4];

    fc_stream_engine #(.DATA_W(8), .IN_LEN(4), .OUT_NUM(4), .LANES(4), .SIGNED(1), .OUT_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .act_mode(act_s[0]), .out_shift(shift_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_data(out_data_s[0]),
        .out_idx(idx0), .busy(busy_s[0]), .done(done_s[0]));

    fc_stream_engine #(.DATA_W(8), .IN_LEN(8), .OUT_NUM(2), .LANES(4), .SIGNED(0), .OUT_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .act_mode(act_s[1]), .out_shift(shift_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_data(out_data_s[1]),
        .out_idx(idx1), .busy(busy_s[1]), .done(done_s[1]));

    always #5 clk = ~clk;

    function automatic int n_of(input int d);   return (d == 0) ? 4 : 8; endfunction
    function automatic int m_of(input int d);   return (d == 0) ? 4 : 2; endfunction
    function automatic bit sgn_of(input int d); return (d == 0);         endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int a, input int b, input int c, input int e);
        return {a[7:0], b[7:0], c[7:0], e[7:0]};
    endfunction

    // Reference: y[m] = clamp(act((b[m] + sum x[k]*W[m][k]) >>> shift)).
    function automatic void model_push(input int d, input int shift, input int act);
        longint acc, lo, hi;
        exp_t   e;
        for (int m = 0; m < m_of(d); m++) begin
            acc = jb[m];
            for (int k = 0; k < n_of(d); k++) acc += longint'(jx[k]) * longint'(jw[m][k]);
            acc = acc >>> shift;
            if (act == 1 && acc < 0) acc = 0;
            if (sgn_of(d)) begin lo = -32768; hi = 32767; end
            else           begin lo = 0;      hi = 65535; end
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
            e.data = {16'd0, acc[15:0]};
            e.idx  = m;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endfunction

    // Per-cycle comparison of one instance's outputs against the expected stream.
    task automatic mon(input int d);
        int   idx;
        int   data;
        exp_t e;
        bit   has;
        idx  = (d == 0) ? int'(idx0) : int'(idx1);
        data = int'(out_data_s[d]);
        if (pend_done[d] || done_s[d]) begin
            chk($sformatf("dut%0d done timing", d), int'(done_s[d]), int'(pend_done[d]));
            if (pend_done[d]) chk($sformatf("dut%0d busy with done", d), int'(busy_s[d]), 0);
        end
        pend_done[d] = 1'b0;
        if (out_valid_s[d]) begin
            has = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!has) begin
                checks++;
                errors++;
                $display("FAIL dut%0d unexpected result: got data %0d idx %0d, required none", d, data, idx);
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                chk($sformatf("dut%0d out_data n%0d", d, e.idx), data, int'(e.data));
                chk($sformatf("dut%0d out_idx", d), idx, int'(e.idx));
                if (out_ready_s[d]) begin
                    if (d == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                    cap[d][e.idx] = data;
                    if (int'(e.idx) == m_of(d) - 1) pend_done[d] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon(0);
                mon(1);
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = never ready.
    initial begin
        out_ready_s[0] = 1'b1;
        out_ready_s[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                out_ready_s[d] = (rmode[d] == 0) ? 1'b1 : (rmode[d] == 1) ? 1'($urandom) : 1'b0;
        end
    end

    task automatic send_beat(input int d, input logic [31:0] data);
        int g;
        if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin in_valid_s[d] = 1'b0; @(posedge clk); #1; end
        end
        in_valid_s[d] = 1'b1;
        in_data_s[d]  = data;
        g = 0;
        do begin @(negedge clk); g++; end while (!in_ready_s[d] && g < LIMIT);
        if (!in_ready_s[d]) begin
            checks++;
            errors++;
            $display("FAIL dut%0d beat timeout: in_ready stayed 0 for %0d cycles, required 1", d, g);
        end
        @(posedge clk);
        #1;
        in_valid_s[d] = 1'b0;
        in_data_s[d]  = $urandom;
    endtask

    task automatic start_job(input int d, input int shift, input int act);
        start_s[d] = 1'b1;
        act_s[d]   = act[1:0];
        shift_s[d] = shift[3:0];
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
        act_s[d]   = 2'($urandom);
        shift_s[d] = 4'($urandom);
    endtask

    task automatic send_x(input int d);
        for (int s = 0; s < n_of(d) / 4; s++)
            send_beat(d, pack(jx[4*s], jx[4*s+1], jx[4*s+2], jx[4*s+3]));
    endtask

    // Hold the stalled last weight beat of neuron 1 and watch the full output register.
    task automatic probe(input int d, input logic [31:0] beat);
        in_valid_s[d] = 1'b1;
        in_data_s[d]  = beat;
        repeat (4) begin
            @(negedge clk);
            chk("bp in_ready low", int'(in_ready_s[d]), 0);
            chk("bp out_valid held", int'(out_valid_s[d]), 1);
            chk("bp out_data held", int'(out_data_s[d]), 10);
            chk("bp out_idx held", int'(idx0), 0);
        end
        rmode[d] = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_neuron(input int d, input int m, input bit bp, input bit spur);
        int          segs;
        logic [31:0] beat;
        segs = n_of(d) / 4;
        send_beat(d, pack(jb[m], int'($urandom), int'($urandom), int'($urandom)));
        if (spur) begin
            start_s[d] = 1'b1;
            act_s[d]   = 2'b01;
            shift_s[d] = 4'd3;
            @(posedge clk);
            #1;
            start_s[d] = 1'b0;
        end
        for (int s = 0; s < segs; s++) begin
            beat = pack(jw[m][4*s], jw[m][4*s+1], jw[m][4*s+2], jw[m][4*s+3]);
            if (bp && m == 1 && s == segs - 1) probe(d, beat);
            send_beat(d, beat);
        end
    endtask

    task automatic wait_done(input int d);
        int g;
        g = 0;
        while (!done_s[d] && g < LIMIT) begin @(negedge clk); g++; end
        if (!done_s[d]) begin
            checks++;
            errors++;
            $display("FAIL dut%0d done timeout: done stayed 0 for %0d cycles, required 1", d, g);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int d, input int shift, input int act, input bit bp, input bit spur);
        for (int i = 0; i < 4; i++) cap[d][i] = -1;
        model_push(d, shift, act);
        start_job(d, shift, act);
        send_x(d);
        for (int m = 0; m < m_of(d); m++) send_neuron(d, m, bp, spur && m == 0);
        wait_done(d);
    endtask

    task automatic load_rows(input bit all127);
        for (int k = 0; k < 4; k++) jx[k] = all127 ? 127 : k + 1;
        for (int k = 0; k < 4; k++) begin
            jw[0][k] = 1;
            jw[1][k] = (k == 0) ? -1 : 0;
            jw[2][k] = 127;
            jw[3][k] = (k == 3) ? 2 : 0;
        end
        jb[0] = 0; jb[1] = 0; jb[2] = 0; jb[3] = 5;
    endtask

    task automatic rand_job(input int d);
        int shift;
        int act;
        for (int k = 0; k < n_of(d); k++)
            jx[k] = sgn_of(d) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 255));
        for (int m = 0; m < m_of(d); m++) begin
            jb[m] = sgn_of(d) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 255));
            for (int k = 0; k < n_of(d); k++)
                jw[m][k] = sgn_of(d) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 255));
        end
        shift = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 9));
        act   = int'($urandom_range(0, 3));
        run_job(d, shift, act, 1'b0, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        gaps = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; act_s[d] = '0; shift_s[d] = '0;
            in_valid_s[d] = 1'b0; in_data_s[d] = '0;
            rmode[d] = 0; pend_done[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", int'(busy_s[0]), 0);
        chk("reset in_ready", int'(in_ready_s[0]), 0);
        chk("reset out_valid", int'(out_valid_s[0]), 0);
        chk("reset done", int'(done_s[0]), 0);
        chk("reset out_data", int'(out_data_s[0]), 0);
        chk("reset out_idx", int'(idx0), 0);
        chk("reset dut1 busy", int'(busy_s[1]), 0);
        chk("reset dut1 out_valid", int'(out_valid_s[1]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle in_ready", int'(in_ready_s[0]), 0);

        // Basic job, with a start pulse injected while loading weights.
        load_rows(1'b0);
        run_job(0, 0, 0, 1'b0, 1'b1);
        chk("job1 n0", cap[0][0], 10);
        chk("job1 n1", cap[0][1], 65535);
        chk("job1 n2", cap[0][2], 1270);
        chk("job1 n3", cap[0][3], 13);

        load_rows(1'b1);
        run_job(0, 0, 0, 1'b0, 1'b0);
        chk("job2 n2 saturated", cap[0][2], 32767);

        load_rows(1'b0);
        run_job(0, 0, 1, 1'b0, 1'b0);
        chk("relu n1", cap[0][1], 0);
        chk("relu n3", cap[0][3], 13);

        load_rows(1'b1);
        run_job(0, 2, 0, 1'b0, 1'b0);
        chk("shift2 n2", cap[0][2], 16129);

        // Output backpressure from the start of the job.
        load_rows(1'b0);
        rmode[0] = 2;
        run_job(0, 0, 0, 1'b1, 1'b0);
        chk("bp n0", cap[0][0], 10);
        chk("bp n1", cap[0][1], 65535);
        chk("bp n2", cap[0][2], 1270);
        chk("bp n3", cap[0][3], 13);

        // Reset during LOAD_W with a result pending.
        rmode[0] = 2;
        model_push(0, 0, 0);
        start_job(0, 0, 0);
        send_x(0);
        send_neuron(0, 0, 1'b0, 1'b0);
        send_beat(0, pack(jb[1], 0, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst busy", int'(busy_s[0]), 0);
        chk("midrst in_ready", int'(in_ready_s[0]), 0);
        chk("midrst out_valid", int'(out_valid_s[0]), 0);
        q0.delete();
        pend_done[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rmode[0] = 1;
        repeat (3) @(posedge clk);
        #1;
        load_rows(1'b0);
        run_job(0, 0, 0, 1'b0, 1'b0);
        chk("after rst n0", cap[0][0], 10);
        chk("after rst n3", cap[0][3], 13);

        // Unsigned 8-long, 2-neuron instance.
        gaps = 1'b1;
        rmode[1] = 1;
        for (int k = 0; k < 8; k++) begin
            jx[k] = k + 1;
            jw[0][k] = 255;
            jw[1][k] = 0;
        end
        jb[0] = 1;
        jb[1] = 200;
        run_job(1, 0, 0, 1'b0, 1'b0);
        chk("dut1 n0", cap[1][0], 9181);
        chk("dut1 n1", cap[1][1], 200);

        // Random jobs on both instances.
        rmode[0] = 1;
        for (int i = 0; i < 10; i++) rand_job(0);
        for (int i = 0; i < 6; i++) rand_job(1);

        repeat (3) @(posedge clk);
        #1;
        chk("final queue0 empty", q0.size(), 0);
        chk("final queue1 empty", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
